// File: rtl/dpram_cfg.sv
// Dual-port RAM: one write port and one read port on a single clock.
// After reset the whole array is cleared to zero, one word per cycle.
// The read latency is 1 or 2 cycles, and read-during-write to the same
// address can return either the old data or the new data.
module dpram_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last;
  logic                  clr_en;
  logic                  wr_en;
  logic                  rd_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;
  logic                  rdw_hit;

  assign clr_last = (clr_cnt == {ADDR_WIDTH{1'b1}});

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  // Next-state logic: leave CLEAR on the edge that writes the last word
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_last) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Output decode: user ports are gated off while the clear runs
  always_comb begin
    busy   = 1'b1;
    clr_en = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_en = 1'b1;
      end
      READY: begin
        busy  = 1'b0;
        wr_en = wen;
        rd_en = ren;
      end
      default: begin
        busy   = 1'b1;
        clr_en = 1'b0;
      end
    endcase
  end

  // Clear address counter; restarts from zero on every reset edge
  always_ff @(posedge clk) begin
    if (reset)       clr_cnt <= '0;
    else if (clr_en) clr_cnt <= clr_cnt + 1'b1;
  end

  // Memory array: the clear sequence and the user write share the one write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_en)     mem[clr_cnt] <= '0;
      else if (wr_en) mem[waddr]   <= data_in;
    end
  end

  // Same-address collision only matters for write-through mode
  assign rdw_hit = (RDW_MODE != 0) && wr_en && (waddr == raddr);

  // ---- stage p1: array read ----
  // Read stage: data holds when no read is issued, valid is a one-cycle strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rd_data_p1 <= rdw_hit ? data_in : mem[raddr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd_data_p2;
      logic                  vld_p2;

      // ---- stage p2: output register ----
      // Output register: flushed by reset so in-flight reads never surface
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_p2 <= '0;
          vld_p2     <= 1'b0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) rd_data_p2 <= rd_data_p1;
        end
      end

      assign data_out = rd_data_p2;
      assign rvalid   = vld_p2;
    end else begin : g_no_out_reg
      assign data_out = rd_data_p1;
      assign rvalid   = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_cfg.sv
// Directed bench for dpram_cfg. Three instances share one stimulus:
// default, write-through read-during-write, and output-registered.
module tb_dpram_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] waddr;
  logic [9:0] raddr;
  logic [7:0] data_in;
  logic       wen;
  logic       ren;

  logic [7:0] dout_a, dout_b, dout_c;
  logic       rv_a, rv_b, rv_c;
  logic       busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dpram_cfg #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .OUT_REG(0), .RDW_MODE(0)) u_dut (
    .clk(clk), .reset(reset), .waddr(waddr), .raddr(raddr), .data_in(data_in),
    .wen(wen), .ren(ren), .data_out(dout_a), .rvalid(rv_a), .busy(busy_a));

  dpram_cfg #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .OUT_REG(0), .RDW_MODE(1)) u_rdw (
    .clk(clk), .reset(reset), .waddr(waddr), .raddr(raddr), .data_in(data_in),
    .wen(wen), .ren(ren), .data_out(dout_b), .rvalid(rv_b), .busy(busy_b));

  dpram_cfg #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .OUT_REG(1), .RDW_MODE(0)) u_oreg (
    .clk(clk), .reset(reset), .waddr(waddr), .raddr(raddr), .data_in(data_in),
    .wen(wen), .ren(ren), .data_out(dout_c), .rvalid(rv_c), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    wen = 1'b1; waddr = a; data_in = d;
    tick();
    wen = 1'b0;
  endtask

  // Issue one read; afterwards the 1-cycle instances show the result
  task automatic rd(input logic [9:0] a);
    ren = 1'b1; raddr = a;
    tick();
    ren = 1'b0;
  endtask

  // Count cycles with busy high (reset already released), bounded
  task automatic count_busy(output int n, output logic rv_seen);
    n = 0;
    rv_seen = 1'b0;
    while (busy_a && n < 2000) begin
      n++;
      rv_seen = rv_seen | rv_a | rv_b | rv_c;
      tick();
    end
    rv_seen = rv_seen | rv_a | rv_b | rv_c;
  endtask

  int   nb;
  logic rvs;

  initial begin
    reset = 1'b1; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; data_in = '0;

    // Reset state
    tick();
    chk("rst_busy", busy_a, 1);
    chk("rst_dout", dout_a, 0);
    chk("rst_rvalid", rv_a, 0);
    chk("rst_dout_oreg", dout_c, 0);

    // Clear sequence with writes/reads hammered during busy
    reset = 1'b0;
    wen = 1'b1; waddr = 10'd9; data_in = 8'hFF;
    ren = 1'b1; raddr = 10'd9;
    count_busy(nb, rvs);
    wen = 1'b0; ren = 1'b0;
    chk("busy_len", nb, 1024);
    chk("busy_rvalid", rvs, 0);
    chk("busy_low", busy_c, 0);

    // Read of a cleared address
    rd(10'd5);
    chk("rd5_data", dout_a, 8'h00);
    chk("rd5_rvalid", rv_a, 1);
    tick();
    chk("rd5_rvalid_drop", rv_a, 0);
    chk("rd5_oreg_rvalid", rv_c, 1);
    chk("rd5_oreg_data", dout_c, 8'h00);

    // Write ignored during busy
    rd(10'd9);
    chk("rd9_data", dout_a, 8'h00);
    chk("rd9_rvalid", rv_a, 1);

    // Write then read
    wr(10'd3, 8'hA5);
    rd(10'd3);
    chk("rd3_data", dout_a, 8'hA5);
    chk("rd3_rvalid", rv_a, 1);
    tick();
    chk("rd3_hold", dout_a, 8'hA5);
    chk("rd3_rvalid_off", rv_a, 0);
    chk("rd3_oreg", dout_c, 8'hA5);

    // Read-during-write, same address
    wr(10'd7, 8'h11);
    wen = 1'b1; ren = 1'b1; waddr = 10'd7; raddr = 10'd7; data_in = 8'h3C;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("rdw_old", dout_a, 8'h11);
    chk("rdw_new", dout_b, 8'h3C);
    tick();
    chk("rdw_old_oreg", dout_c, 8'h11);
    rd(10'd7);
    chk("rdw_after_a", dout_a, 8'h3C);
    chk("rdw_after_b", dout_b, 8'h3C);

    // Simultaneous write and read at different addresses
    wen = 1'b1; ren = 1'b1; waddr = 10'd20; raddr = 10'd3; data_in = 8'h77;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("wr_rd_diff_rd", dout_a, 8'hA5);
    chk("wr_rd_diff_rdw", dout_b, 8'hA5);
    rd(10'd20);
    chk("wr_rd_diff_wr", dout_a, 8'h77);

    // Top address
    wr(10'd1023, 8'hEE);
    rd(10'd1023);
    chk("rd1023", dout_a, 8'hEE);

    // Back-to-back reads, both latencies
    for (int i = 0; i < 4; i++) wr(10'(i), 8'(8'h10 + i));
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin ren = 1'b1; raddr = 10'(i); end
      else ren = 1'b0;
      tick();
      if (i < 4) begin
        chk($sformatf("burst_a_d%0d", i), dout_a, 8'h10 + i);
        chk($sformatf("burst_a_v%0d", i), rv_a, 1);
      end
      if (i >= 1 && i <= 4) begin
        chk($sformatf("burst_c_d%0d", i), dout_c, 8'h10 + i - 1);
        chk($sformatf("burst_c_v%0d", i), rv_c, 1);
      end
      if (i == 0 || i == 5) chk($sformatf("burst_c_idle%0d", i), rv_c, 0);
    end

    // Reset in READY flushes an in-flight read
    wr(10'd1000, 8'h5A);
    ren = 1'b1; raddr = 10'd1000;
    tick();
    ren = 1'b0; reset = 1'b1;
    tick();
    chk("flush_rvalid", rv_c, 0);
    chk("flush_dout", dout_c, 0);
    chk("flush_dout_a", dout_a, 0);
    chk("flush_busy", busy_a, 1);

    // Reset again mid-clear at count 500
    reset = 1'b0;
    repeat (500) tick();
    chk("mid_busy", busy_a, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(nb, rvs);
    chk("busy_len2", nb, 1024);

    rd(10'd1000);
    chk("rd1000_cleared", dout_a, 8'h00);
    chk("rd1000_rvalid", rv_a, 1);
    rd(10'd3);
    chk("rd3_cleared", dout_a, 8'h00);
    rd(10'd1023);
    chk("rd1023_cleared", dout_b, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
